sisc_ctrl_hs: RTL and testbench

Parametrised multicycle control FSM for the SISC datapath. It sequences fetch, decode, execute, memory and writeback, and adds four capabilities:
- ready/acknowledge handshakes to instruction and data memory, with a wait timeout;
- an explicit HALT state in place of a simulation stop;
- short-cut branch and NOOP paths that return to FETCH after DECODE;
- a two-cycle swap writeback.

It sits between the IR/status register and the PC, register file, ALU and data-memory muxes.

---
 rtl/sisc_pkg.sv | 51 +++++
 rtl/sisc_wait_timer.sv | 29 ++
 rtl/sisc_ctrl_hs.sv | 177 +++++++++++++++++
 tb/tb_sisc_ctrl_hs.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/sisc_pkg.sv
// Shared definitions for the SISC multicycle controller: opcodes, FSM states,
// ALU mode and writeback-source codes.
package sisc_pkg;

    localparam logic [3:0] OP_NOOP = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_SWP  = 4'd3;
    localparam logic [3:0] OP_NOT  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_AND  = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_RTR  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;
    localparam logic [3:0] OP_LOD  = 4'd10;
    localparam logic [3:0] OP_STR  = 4'd11;
    localparam logic [3:0] OP_BRA  = 4'd12;
    localparam logic [3:0] OP_BRR  = 4'd13;
    localparam logic [3:0] OP_BNE  = 4'd14;
    localparam logic [3:0] OP_HLT  = 4'd15;

    typedef enum logic [2:0] {
        StStart  = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StWb2    = 3'd6,
        StHalt   = 3'd7
    } state_e;

    localparam logic [1:0] ALU_REG  = 2'b00;
    localparam logic [1:0] ALU_IMM  = 2'b01;
    localparam logic [1:0] ALU_MREG = 2'b10;
    localparam logic [1:0] ALU_MIMM = 2'b11;

    localparam logic [1:0] WB_ALU   = 2'd0;
    localparam logic [1:0] WB_MEM   = 2'd1;
    localparam logic [1:0] WB_SWAP  = 2'd2;
    localparam logic [1:0] WB_SWAP2 = 2'd3;

    function automatic logic is_alu_op(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB, OP_NOT, OP_OR, OP_AND, OP_XOR, OP_RTR, OP_SHR};
    endfunction

    function automatic logic is_branch(input logic [3:0] op);
        return op inside {OP_BRA, OP_BRR, OP_BNE};
    endfunction

endpackage

// File: rtl/sisc_wait_timer.sv
// Memory-ack wait counter; expired flags MEM_TO consecutive cycles without an ack.
module sisc_wait_timer #(
    parameter int unsigned MEM_TO = 15
) (
    input  logic clk,
    input  logic rst_f,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = $clog2(MEM_TO + 1);
    localparam logic [CW-1:0] LIMIT = CW'(MEM_TO);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/sisc_ctrl_hs.sv
// SISC multicycle control FSM with memory handshakes, wait timeout, HALT state,
// short branch/NOOP paths and two-cycle swap writeback.
module sisc_ctrl_hs
    import sisc_pkg::*;
#(
    parameter int unsigned CC_W     = 4,
    parameter int unsigned IMM_MODE = 8,
    parameter int unsigned MEM_TO   = 15
) (
    input  logic            clk,
    input  logic            rst_f,
    input  logic [3:0]      opcode,
    input  logic [CC_W-1:0] mm,
    input  logic [CC_W-1:0] stat,
    input  logic            im_ack,
    input  logic            dm_ack,
    output logic            im_req,
    output logic            dm_req,
    output logic            rf_we,
    output logic            rb_sel,
    output logic            pc_sel,
    output logic            pc_write,
    output logic            pc_rst,
    output logic            ir_load,
    output logic            br_sel,
    output logic            mux_16_sel,
    output logic            dm_we,
    output logic            mux4_swap_sel,
    output logic            swap_ctrl,
    output logic [1:0]      alu_op,
    output logic [1:0]      wb_sel,
    output logic [2:0]      state,
    output logic            halted,
    output logic            fault
);

    localparam logic [CC_W-1:0] IMM_CODE = CC_W'(IMM_MODE);

    state_e          state_q;
    logic [3:0]      op_q;
    logic [CC_W-1:0] mm_q;
    logic            waiting, ack, expired, imm_q, cc_hit;

    assign waiting = (state_q == StFetch) || (state_q == StMem);
    assign ack     = (state_q == StFetch) ? im_ack : dm_ack;
    assign imm_q   = (mm_q == IMM_CODE);
    assign cc_hit  = |(stat & mm);
    assign state   = state_q;

    // Clearing whenever not waiting (or on the ack that ends a wait) gives a
    // zero count on every entry to FETCH or MEM.
    sisc_wait_timer #(
        .MEM_TO (MEM_TO)
    ) u_timer (
        .clk     (clk),
        .rst_f   (rst_f),
        .clr     (!waiting || ack),
        .en      (waiting && !ack),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q <= StStart;
            op_q    <= OP_NOOP;
            mm_q    <= '0;
            halted  <= 1'b0;
            fault   <= 1'b0;
        end else begin
            unique case (state_q)
                StStart: state_q <= StFetch;
                StFetch: begin
                    if (im_ack) begin
                        state_q <= StDecode;
                    end else if (expired) begin
                        state_q <= StHalt;
                        halted  <= 1'b1;
                        fault   <= 1'b1;
                    end
                end
                StDecode: begin
                    op_q <= opcode;
                    mm_q <= mm;
                    if (is_branch(opcode) || opcode == OP_NOOP) begin
                        state_q <= StFetch;
                    end else if (opcode == OP_HLT) begin
                        state_q <= StHalt;
                        halted  <= 1'b1;
                    end else begin
                        state_q <= StExec;
                    end
                end
                StExec: state_q <= (op_q == OP_LOD || op_q == OP_STR) ? StMem : StWb;
                StMem: begin
                    if (dm_ack) begin
                        state_q <= (op_q == OP_STR) ? StFetch : StWb;
                    end else if (expired) begin
                        state_q <= StHalt;
                        halted  <= 1'b1;
                        fault   <= 1'b1;
                    end
                end
                StWb:    state_q <= (op_q == OP_SWP) ? StWb2 : StFetch;
                StWb2:   state_q <= StFetch;
                StHalt:  state_q <= StHalt;
                default: state_q <= StStart;
            endcase
        end
    end

    always_comb begin
        im_req        = 1'b0;
        dm_req        = 1'b0;
        rf_we         = 1'b0;
        rb_sel        = 1'b0;
        pc_sel        = 1'b0;
        pc_write      = 1'b0;
        pc_rst        = 1'b0;
        ir_load       = 1'b0;
        br_sel        = 1'b0;
        mux_16_sel    = 1'b0;
        dm_we         = 1'b0;
        mux4_swap_sel = 1'b0;
        swap_ctrl     = 1'b0;
        alu_op        = ALU_REG;
        wb_sel        = WB_ALU;
        unique case (state_q)
            StStart: pc_rst = 1'b1;
            StFetch: begin
                im_req   = 1'b1;
                ir_load  = im_ack;
                pc_write = im_ack;
            end
            StDecode: begin
                rb_sel = (opcode == OP_STR) || (opcode == OP_SWP);
                unique case (opcode)
                    OP_BRA: begin pc_sel = 1'b1; br_sel = 1'b1; pc_write = cc_hit;  end
                    OP_BRR: begin pc_sel = 1'b1; br_sel = 1'b0; pc_write = cc_hit;  end
                    OP_BNE: begin pc_sel = 1'b1; br_sel = 1'b1; pc_write = !cc_hit; end
                    default: ;
                endcase
            end
            StExec: begin
                rb_sel = (op_q == OP_STR) || (op_q == OP_SWP);
                if (is_alu_op(op_q)) begin
                    alu_op = imm_q ? ALU_IMM : ALU_REG;
                end else if (op_q == OP_LOD || op_q == OP_STR) begin
                    alu_op = imm_q ? ALU_MIMM : ALU_MREG;
                end else if (op_q == OP_SWP) begin
                    swap_ctrl = 1'b1;
                    wb_sel    = WB_SWAP;
                end
            end
            StMem: begin
                rb_sel     = (op_q == OP_STR);
                dm_req     = 1'b1;
                mux_16_sel = imm_q;
                dm_we      = (op_q == OP_STR);
            end
            StWb: begin
                rb_sel = (op_q == OP_SWP);
                rf_we  = 1'b1;
                if (op_q == OP_LOD)      wb_sel = WB_MEM;
                else if (op_q == OP_SWP) wb_sel = WB_SWAP;
                else                     wb_sel = WB_ALU;
            end
            StWb2: begin
                rb_sel        = 1'b1;
                rf_we         = 1'b1;
                wb_sel        = WB_SWAP2;
                mux4_swap_sel = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sisc_ctrl_hs.sv
// Directed bench for sisc_ctrl_hs: walks each instruction class cycle by cycle
// and compares state plus the packed control vector against hand-derived values.
module tb_sisc_ctrl_hs;

    logic       clk = 1'b0;
    logic       rst_f;
    logic [3:0] opcode, mm, stat;
    logic       im_ack, dm_ack;
    logic       im_req, dm_req, rf_we, rb_sel, pc_sel, pc_write, pc_rst, ir_load;
    logic       br_sel, mux_16_sel, dm_we, mux4_swap_sel, swap_ctrl;
    logic [1:0] alu_op, wb_sel;
    logic [2:0] state;
    logic       halted, fault;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sisc_ctrl_hs #(
        .CC_W     (4),
        .IMM_MODE (8),
        .MEM_TO   (3)
    ) dut (
        .clk           (clk),
        .rst_f         (rst_f),
        .opcode        (opcode),
        .mm            (mm),
        .stat          (stat),
        .im_ack        (im_ack),
        .dm_ack        (dm_ack),
        .im_req        (im_req),
        .dm_req        (dm_req),
        .rf_we         (rf_we),
        .rb_sel        (rb_sel),
        .pc_sel        (pc_sel),
        .pc_write      (pc_write),
        .pc_rst        (pc_rst),
        .ir_load       (ir_load),
        .br_sel        (br_sel),
        .mux_16_sel    (mux_16_sel),
        .dm_we         (dm_we),
        .mux4_swap_sel (mux4_swap_sel),
        .swap_ctrl     (swap_ctrl),
        .alu_op        (alu_op),
        .wb_sel        (wb_sel),
        .state         (state),
        .halted        (halted),
        .fault         (fault)
    );

    // Bit masks into the packed control vector below.
    localparam logic [16:0] IMREQ = 17'h10000;
    localparam logic [16:0] DMREQ = 17'h08000;
    localparam logic [16:0] RFWE  = 17'h04000;
    localparam logic [16:0] RBSEL = 17'h02000;
    localparam logic [16:0] PCSEL = 17'h01000;
    localparam logic [16:0] PCWR  = 17'h00800;
    localparam logic [16:0] PCRST = 17'h00400;
    localparam logic [16:0] IRLD  = 17'h00200;
    localparam logic [16:0] BRSEL = 17'h00100;
    localparam logic [16:0] M16   = 17'h00080;
    localparam logic [16:0] DMWE  = 17'h00040;
    localparam logic [16:0] M4S   = 17'h00020;
    localparam logic [16:0] SWAPC = 17'h00010;
    localparam logic [16:0] ALU1  = 17'h00004;
    localparam logic [16:0] ALU2  = 17'h00008;
    localparam logic [16:0] ALU3  = 17'h0000C;
    localparam logic [16:0] WB1   = 17'h00001;
    localparam logic [16:0] WB2   = 17'h00002;
    localparam logic [16:0] WB3   = 17'h00003;

    logic [16:0] ctl;
    assign ctl = {im_req, dm_req, rf_we, rb_sel, pc_sel, pc_write, pc_rst, ir_load, br_sel,
                  mux_16_sel, dm_we, mux4_swap_sel, swap_ctrl, alu_op, wb_sel};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Settle combinational outputs, then check state and full control vector.
    task automatic expect_sc(input string tag, input logic [2:0] st, input logic [16:0] c);
        #1;
        chk({tag, ".state"}, 32'(state), 32'(st));
        chk({tag, ".ctl"}, 32'(ctl), 32'(c));
    endtask

    task automatic expect_flags(input string tag, input logic h, input logic f);
        chk({tag, ".halted"}, 32'(halted), 32'(h));
        chk({tag, ".fault"}, 32'(fault), 32'(f));
    endtask

    initial begin
        rst_f = 1'b0; opcode = 4'd0; mm = 4'd0; stat = 4'd0;
        im_ack = 1'b0; dm_ack = 1'b0;
        #2;
        expect_sc("reset", 3'd0, PCRST);
        expect_flags("reset", 1'b0, 1'b0);

        // ADD reg, acks tied high
        cyc();
        rst_f = 1'b1; im_ack = 1'b1; dm_ack = 1'b1; opcode = 4'd1; mm = 4'd0;
        expect_sc("add.start", 3'd0, PCRST);
        cyc(); expect_sc("add.fetch", 3'd1, IMREQ | PCWR | IRLD);
        cyc(); expect_sc("add.decode", 3'd2, '0);
        cyc(); expect_sc("add.exec", 3'd3, '0);
        cyc(); expect_sc("add.wb", 3'd5, RFWE);
        cyc();
        opcode = 4'd10; mm = 4'd8; dm_ack = 1'b0;
        expect_sc("lod.fetch", 3'd1, IMREQ | PCWR | IRLD);

        // LOD imm, dm_ack arrives in the 4th MEM cycle (the expiry cycle)
        cyc(); expect_sc("lod.decode", 3'd2, '0);
        cyc(); expect_sc("lod.exec", 3'd3, ALU3);
        cyc(); expect_sc("lod.mem1", 3'd4, DMREQ | M16);
        cyc(); expect_sc("lod.mem2", 3'd4, DMREQ | M16);
        cyc(); expect_sc("lod.mem3", 3'd4, DMREQ | M16);
        cyc(); dm_ack = 1'b1;
        expect_sc("lod.mem4", 3'd4, DMREQ | M16);
        cyc(); dm_ack = 1'b0;
        expect_sc("lod.wb", 3'd5, RFWE | WB1);
        expect_flags("lod.wb", 1'b0, 1'b0);
        cyc();
        opcode = 4'd12; mm = 4'd2; stat = 4'd2;
        expect_sc("bra.fetch", 3'd1, IMREQ | PCWR | IRLD);

        // Branches
        cyc(); expect_sc("bra.decode", 3'd2, PCSEL | BRSEL | PCWR);
        cyc(); opcode = 4'd14;
        expect_sc("bne.fetch", 3'd1, IMREQ | PCWR | IRLD);
        cyc(); expect_sc("bne.decode", 3'd2, PCSEL | BRSEL);
        cyc(); opcode = 4'd13; stat = 4'd4;
        expect_sc("brr.fetch", 3'd1, IMREQ | PCWR | IRLD);
        cyc(); expect_sc("brr.decode", 3'd2, PCSEL);
        cyc(); opcode = 4'd3; mm = 4'd0;
        expect_sc("swp.fetch", 3'd1, IMREQ | PCWR | IRLD);

        // SWP; opcode changed after DECODE must not matter
        cyc(); expect_sc("swp.decode", 3'd2, RBSEL);
        cyc(); opcode = 4'd1;
        expect_sc("swp.exec", 3'd3, RBSEL | SWAPC | WB2);
        cyc(); expect_sc("swp.wb", 3'd5, RBSEL | RFWE | WB2);
        cyc(); expect_sc("swp.wb2", 3'd6, RBSEL | RFWE | WB3 | M4S);
        cyc(); opcode = 4'd0;
        expect_sc("noop.fetch", 3'd1, IMREQ | PCWR | IRLD);
        cyc(); expect_sc("noop.decode", 3'd2, '0);
        cyc(); opcode = 4'd11; mm = 4'd0;
        expect_sc("str.fetch", 3'd1, IMREQ | PCWR | IRLD);

        // STR, reset asserted while in MEM
        cyc(); expect_sc("str.decode", 3'd2, RBSEL);
        cyc(); expect_sc("str.exec", 3'd3, RBSEL | ALU2);
        cyc(); expect_sc("str.mem", 3'd4, RBSEL | DMREQ | DMWE);
        rst_f = 1'b0;
        expect_sc("str.rst", 3'd0, PCRST);

        // Fetch ack arrives in the expiry cycle
        cyc(); rst_f = 1'b1; im_ack = 1'b0; opcode = 4'd0;
        cyc(); expect_sc("late.f1", 3'd1, IMREQ);
        cyc(); expect_sc("late.f2", 3'd1, IMREQ);
        cyc(); expect_sc("late.f3", 3'd1, IMREQ);
        cyc(); im_ack = 1'b1;
        expect_sc("late.f4", 3'd1, IMREQ | PCWR | IRLD);
        cyc(); im_ack = 1'b0;
        expect_sc("late.decode", 3'd2, '0);
        expect_flags("late.decode", 1'b0, 1'b0);

        // Fetch ack never arrives
        cyc(); expect_sc("to.f1", 3'd1, IMREQ);
        cyc(); expect_sc("to.f2", 3'd1, IMREQ);
        cyc(); expect_sc("to.f3", 3'd1, IMREQ);
        cyc(); expect_sc("to.f4", 3'd1, IMREQ);
        cyc(); expect_sc("to.halt", 3'd7, '0);
        expect_flags("to.halt", 1'b1, 1'b1);
        cyc(); im_ack = 1'b1;
        expect_sc("to.absorb", 3'd7, '0);

        // HLT
        rst_f = 1'b0; opcode = 4'd15;
        #1;
        expect_flags("hlt.rst", 1'b0, 1'b0);
        cyc(); rst_f = 1'b1;
        cyc(); expect_sc("hlt.fetch", 3'd1, IMREQ | PCWR | IRLD);
        cyc(); expect_sc("hlt.decode", 3'd2, '0);
        cyc(); expect_sc("hlt.halt", 3'd7, '0);
        expect_flags("hlt.halt", 1'b1, 1'b0);
        cyc(); opcode = 4'd1;
        expect_sc("hlt.absorb", 3'd7, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
